// File: rtl/spi_ram_arbiter_if.sv
// spi_ram_arbiter_if: per-master SPI slave ports plus the shared serial-RAM bus
interface spi_ram_arbiter_if #(
  parameter int N_MASTERS = 2,
  parameter int OWN_W     = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1
);
  logic [N_MASTERS-1:0] spi_nss, spi_sck, spi_mosi, spi_miso, spi_miso_oe, mbox_irq;
  logic                 ram_nss, ram_sck, ram_mosi, ram_miso, ram_busy;
  logic [OWN_W-1:0]     ram_owner;
  modport slave (
    input  spi_nss, spi_sck, spi_mosi, ram_miso,
    output spi_miso, spi_miso_oe, ram_nss, ram_sck, ram_mosi, ram_owner, ram_busy, mbox_irq
  );
  modport master (
    output spi_nss, spi_sck, spi_mosi, ram_miso,
    input  spi_miso, spi_miso_oe, ram_nss, ram_sck, ram_mosi, ram_owner, ram_busy, mbox_irq
  );
endinterface

// File: rtl/spi_ram_arbiter.sv
// spi_ram_arbiter: clk-domain SPI-slave hub sharing one serial RAM and per-master mailboxes
module spi_ram_arbiter #(
  parameter int N_MASTERS   = 2,
  parameter int SYNC_STAGES = 2,
  parameter int DATA_W      = 8
) (
  input logic              clk,
  input logic              reset,
  spi_ram_arbiter_if.slave bus
);
  localparam int OWN_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
  localparam int CW    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  typedef enum logic [2:0] {IDLE, OPCODE, WR_MBOX, RD_MBOX, RAM, RD_STAT, DISCARD} st_t;
  logic [N_MASTERS-1:0] req, win, gnt, nss_rise, wr_en, clr, miso, oe, irq, irq_set;
  logic [DATA_W-1:0]    rx_byte [N_MASTERS];
  logic [DATA_W-1:0]    mbox [N_MASTERS];
  logic                 busy, gnt_any, rel;
  logic [OWN_W-1:0]     owner, rr, gnt_idx;
  // lowest rotated index from rr wins
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int k = N_MASTERS - 1; k >= 0; k--)
      if (req[(int'(rr) + k) % N_MASTERS]) begin
        gnt_any = 1'b1;
        gnt_idx = OWN_W'((int'(rr) + k) % N_MASTERS);
      end
  end
  assign win = (gnt_any && !busy) ? (N_MASTERS'(1) << gnt_idx) : '0;
  assign gnt = busy ? (N_MASTERS'(1) << owner) : '0;
  assign rel = busy && nss_rise[owner];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      busy  <= 1'b0;
      owner <= '0;
      rr    <= '0;
    end else if (rel) begin
      busy <= 1'b0;
    end else if (!busy && gnt_any) begin
      busy  <= 1'b1;
      owner <= gnt_idx;
      rr    <= (int'(gnt_idx) == N_MASTERS - 1) ? '0 : gnt_idx + 1'b1;
    end
  // a write by master i flags the mailbox to master i+1; set beats clear
  assign irq_set = {wr_en[N_MASTERS-2:0], wr_en[N_MASTERS-1]};
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      irq <= '0;
      for (int k = 0; k < N_MASTERS; k++) mbox[k] <= '0;
    end else begin
      irq <= (irq & ~clr) | irq_set;
      for (int k = 0; k < N_MASTERS; k++) if (wr_en[k]) mbox[k] <= rx_byte[k];
    end
  assign bus.spi_miso    = miso;
  assign bus.spi_miso_oe = oe;
  assign bus.mbox_irq    = irq;
  assign bus.ram_nss     = !busy;
  assign bus.ram_sck     = busy && bus.spi_sck[owner];
  assign bus.ram_mosi    = busy && bus.spi_mosi[owner];
  assign bus.ram_owner   = owner;
  assign bus.ram_busy    = busy;
  genvar i;
  for (i = 0; i < N_MASTERS; i++) begin : g_port
    localparam int PREV = (i + N_MASTERS - 1) % N_MASTERS;
    st_t                    st, nxt;
    logic [SYNC_STAGES-1:0] nss_sr, sck_sr, mosi_sr;
    logic                   nss_q, sck_q, miso_q, nak, rd_first, nss_n, rise, fall, done;
    logic [CW-1:0]          cnt;
    logic [DATA_W-1:0]      rx, tx, rx_nxt, stat, load;
    assign nss_n       = nss_sr[SYNC_STAGES-1];
    assign nss_rise[i] = !nss_q && nss_n;
    assign rise        = sck_sr[SYNC_STAGES-1] && !sck_q && !nss_n;
    assign fall        = !sck_sr[SYNC_STAGES-1] && sck_q && !nss_n;
    assign done        = rise && cnt == CW'(DATA_W - 1);
    assign rx_nxt      = {rx[DATA_W-2:0], mosi_sr[SYNC_STAGES-1]};
    assign stat        = DATA_W'({busy, irq[i], gnt[i], 1'b0, 4'(owner)}) << (DATA_W - 8);
    // transmit data is captured at byte start, so a same-clk mailbox write is seen next byte
    assign load        = (nxt == RD_MBOX) ? mbox[PREV] : (nxt == RD_STAT) ? stat : '0;
    assign req[i]      = st == RAM && !gnt[i];
    assign wr_en[i]    = st == WR_MBOX && done;
    assign clr[i]      = st == RD_MBOX && done && rd_first;
    assign rx_byte[i]  = rx_nxt;
    assign miso[i]     = gnt[i] ? bus.ram_miso : (st == DISCARD) ? nak : miso_q;
    assign oe[i]       = gnt[i] || !nss_n;
    always_comb begin
      nxt = st;
      if (nss_rise[i]) nxt = IDLE;
      else if (st == IDLE && nss_q && !nss_n) nxt = OPCODE;
      else if (st == OPCODE && done)
        nxt = (rx_nxt == DATA_W'(1)) ? WR_MBOX :
              (rx_nxt == DATA_W'(2)) ? RD_MBOX :
              (rx_nxt == DATA_W'(3)) ? RAM :
              (rx_nxt == DATA_W'(4)) ? RD_STAT : DISCARD;
      else if (st == RAM && !gnt[i] && !win[i]) nxt = DISCARD;
    end
    always_ff @(posedge clk or posedge reset)
      if (reset) begin
        st       <= IDLE;
        nss_sr   <= '1;
        sck_sr   <= '0;
        mosi_sr  <= '0;
        nss_q    <= 1'b1;
        sck_q    <= 1'b0;
        cnt      <= '0;
        rx       <= '0;
        tx       <= '0;
        miso_q   <= 1'b0;
        nak      <= 1'b0;
        rd_first <= 1'b0;
      end else begin
        st       <= nxt;
        nss_sr   <= {nss_sr[SYNC_STAGES-2:0], bus.spi_nss[i]};
        sck_sr   <= {sck_sr[SYNC_STAGES-2:0], bus.spi_sck[i]};
        mosi_sr  <= {mosi_sr[SYNC_STAGES-2:0], bus.spi_mosi[i]};
        nss_q    <= nss_n;
        sck_q    <= sck_sr[SYNC_STAGES-1];
        nak      <= (st == RAM && nxt == DISCARD) || (nak && nxt != IDLE);
        rd_first <= (nxt == RD_MBOX) && (st == OPCODE || (rd_first && !done));
        if (st == IDLE && nxt == OPCODE) begin
          cnt    <= '0;
          rx     <= '0;
          tx     <= '0;
          miso_q <= 1'b0;
        end else if (rise) begin
          cnt <= done ? '0 : cnt + 1'b1;
          rx  <= rx_nxt;
          if (done) tx <= load;
        end else if (fall) begin
          miso_q <= tx[DATA_W-1];
          tx     <= tx << 1;
        end
      end
  end
endmodule

// File: tb/tb_spi_ram_arbiter.sv
// tb_spi_ram_arbiter: directed-vector bench for the two-master SPI/RAM hub
module tb_spi_ram_arbiter;
  localparam int H = 6;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  int         n_vec = 0, n_err = 0, sck_edges = 0, base = 0;
  logic [7:0] r0, r1;
  spi_ram_arbiter_if #(.N_MASTERS(2)) bus ();
  spi_ram_arbiter #(.N_MASTERS(2), .SYNC_STAGES(2), .DATA_W(8)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave)
  );
  always #5 clk = ~clk;
  // serial RAM model: echoes the inverted MOSI bit
  assign bus.ram_miso = ~bus.ram_mosi;
  always @(posedge bus.ram_sck) sck_edges++;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic sel(input int m);
    bus.spi_nss[m] = 1'b0;
    wclk(H);
  endtask
  task automatic desel(input int m);
    wclk(H);
    bus.spi_nss[m] = 1'b1;
    wclk(2 * H);
  endtask
  task automatic xfer(input int m, input logic [7:0] d, input int nbits, output logic [7:0] q);
    q = '0;
    for (int b = 7; b > 7 - nbits; b--) begin
      bus.spi_mosi[m] = d[b];
      wclk(H);
      q[b] = bus.spi_miso[m];
      bus.spi_sck[m] = 1'b1;
      wclk(H);
      bus.spi_sck[m] = 1'b0;
    end
  endtask
  task automatic check_reset_outputs(input string tag);
    check({tag, "_ram_nss"}, bus.ram_nss, 1);
    check({tag, "_ram_busy"}, bus.ram_busy, 0);
    check({tag, "_ram_sck"}, bus.ram_sck, 0);
    check({tag, "_ram_mosi"}, bus.ram_mosi, 0);
    check({tag, "_ram_owner"}, bus.ram_owner, 0);
    check({tag, "_miso"}, bus.spi_miso, 0);
    check({tag, "_miso_oe"}, bus.spi_miso_oe, 0);
    check({tag, "_mbox_irq"}, bus.mbox_irq, 0);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish, %0d vectors applied", n_vec);
    $fatal(1);
  end
  initial begin
    bus.spi_nss  = '1;
    bus.spi_sck  = '0;
    bus.spi_mosi = '0;
    wclk(3);
    check_reset_outputs("rst");
    reset = 1'b0;
    wclk(4);
    // mailbox M0 -> M1
    sel(0); xfer(0, 8'h01, 8, r0); xfer(0, 8'hA5, 8, r0); wclk(2);
    check("t1_irq_set", bus.mbox_irq, 2'b10);
    desel(0);
    sel(1); xfer(1, 8'h02, 8, r1);
    check("t1_oe", bus.spi_miso_oe, 2'b10);
    check("t1_irq_held", bus.mbox_irq, 2'b10);
    xfer(1, 8'h00, 8, r1); wclk(2);
    check("t1_rd_mbox", r1, 8'hA5);
    check("t1_irq_clr", bus.mbox_irq, 2'b00);
    desel(1);
    // aborted data byte leaves the mailbox untouched and the framing intact
    sel(0); xfer(0, 8'h01, 8, r0); xfer(0, 8'h3C, 5, r0); desel(0);
    check("t6_irq_untouched", bus.mbox_irq, 2'b00);
    sel(1); xfer(1, 8'h02, 8, r1); xfer(1, 8'h00, 8, r1); desel(1);
    check("t6_mbox_kept", r1, 8'hA5);
    sel(0); xfer(0, 8'h01, 8, r0); xfer(0, 8'h5A, 8, r0); desel(0);
    check("t6_redecode_irq", bus.mbox_irq, 2'b10);
    sel(1); xfer(1, 8'h02, 8, r1); xfer(1, 8'h00, 8, r1); desel(1);
    check("t6_new_mbox", r1, 8'h5A);
    check("t6_irq_clr", bus.mbox_irq, 2'b00);
    // simultaneous RAM requests with rr at 0
    fork
      begin sel(0); xfer(0, 8'h03, 8, r0); xfer(0, 8'h00, 8, r0); end
      begin sel(1); xfer(1, 8'h03, 8, r1); xfer(1, 8'h00, 8, r1); end
    join
    check("t3_owner", bus.ram_owner, 0);
    check("t3_busy", bus.ram_busy, 1);
    check("t3_ram_nss", bus.ram_nss, 0);
    check("t3_m0_ram_miso", r0, 8'hFF);
    check("t3_m1_busy_ff", r1, 8'hFF);
    check("t3_oe", bus.spi_miso_oe, 2'b11);
    fork desel(0); desel(1); join
    check("t3_released", bus.ram_busy, 0);
    sel(1); xfer(1, 8'h03, 8, r1); wclk(2);
    check("t3_retry_owner", bus.ram_owner, 1);
    check("t3_retry_busy", bus.ram_busy, 1);
    desel(1);
    check("t3_retry_rel_nss", bus.ram_nss, 1);
    // M0 RAM burst with M1 status polling during and after
    sel(0); xfer(0, 8'h03, 8, r0); wclk(2);
    check("t2_ram_nss", bus.ram_nss, 0);
    check("t2_owner", bus.ram_owner, 0);
    base = sck_edges;
    xfer(0, 8'h3C, 8, r0); check("t2_loop0", r0, 8'hC3);
    xfer(0, 8'hA5, 8, r0); check("t2_loop1", r0, 8'h5A);
    sel(1); xfer(1, 8'h04, 8, r1); xfer(1, 8'h00, 8, r1); desel(1);
    check("t4_stat_busy", r1, 8'h80);
    xfer(0, 8'h0F, 8, r0); check("t2_loop2", r0, 8'hF0);
    xfer(0, 8'h81, 8, r0); check("t2_loop3", r0, 8'h7E);
    check("t2_sck_mirror", sck_edges - base, 32);
    wclk(H);
    check("t2_held_nss", bus.ram_nss, 0);
    desel(0);
    check("t2_rel_nss", bus.ram_nss, 1);
    check("t2_rel_busy", bus.ram_busy, 0);
    sel(1); xfer(1, 8'h04, 8, r1); xfer(1, 8'h00, 8, r1); desel(1);
    check("t4_stat_free", r1, 8'h00);
    // reset in the middle of a RAM burst, with a mailbox flag pending
    sel(0); xfer(0, 8'h01, 8, r0); xfer(0, 8'h77, 8, r0); desel(0);
    check("t5_irq_pre", bus.mbox_irq, 2'b10);
    sel(0); xfer(0, 8'h03, 8, r0); xfer(0, 8'h00, 8, r0);
    bus.spi_sck[0] = 1'b1;
    wclk(2);
    check("t5_pre_sck", bus.ram_sck, 1);
    #3 reset = 1'b1;
    #1 check_reset_outputs("t5");
    bus.spi_sck[0] = 1'b0;
    bus.spi_nss[0] = 1'b1;
    wclk(2);
    reset = 1'b0;
    wclk(2 * H);
    sel(1); xfer(1, 8'h02, 8, r1); xfer(1, 8'h00, 8, r1); desel(1);
    check("t5_mbox_cleared", r1, 8'h00);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
